// File: rtl/piso_serializer.sv
// piso_serializer
//   Parallel-in/serial-out serializer with a one-word holding buffer so that
//   consecutive words stream with no idle bit between them. dout feeds the
//   din of a downstream serial-in/parallel-out shift register.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | nothing in flight; dout/dvalid held low, waiting for a load
//   SHIFT | a word is on the line; cnt_q is the index of the bit on dout
//
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset, clears everything at once
//   load   : word-offer strobe, accepted on an edge where load && ready
//   din    : parallel word, sampled only on an accepted load
//   ready  : registered, 1 when a word can be accepted this cycle
//   dout   : registered serial data
//   dvalid : registered, 1 while dout carries a valid bit
//   done   : registered one-cycle pulse after the last bit of each word
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             dout,
  output logic             dvalid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  // Bit position of shreg that is presented on dout.
  localparam int FIRST = (MSB_FIRST != 0) ? WIDTH - 1 : 0;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             ready_q, ready_d;
  logic             dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             done_q, done_d;

  logic             accept;
  logic [WIDTH-1:0] shifted;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      hold_q    <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      ready_q   <= 1'b1;
      dout_q    <= 1'b0;
      dvalid_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      dout_q    <= dout_d;
      dvalid_q  <= dvalid_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    accept = load && ready_q;

    // Move the next bit into the output position.
    if (MSB_FIRST != 0) shifted = {shreg_q[WIDTH-2:0], 1'b0};
    else                shifted = {1'b0, shreg_q[WIDTH-1:1]};

    state_d   = state_q;
    shreg_d   = shreg_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    ready_d   = ready_q;
    dout_d    = dout_q;
    dvalid_d  = dvalid_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        dout_d   = 1'b0;
        dvalid_d = 1'b0;
        if (accept) begin
          shreg_d  = din;
          dout_d   = din[FIRST];
          dvalid_d = 1'b1;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        if (cnt_q != LAST) begin
          shreg_d = shifted;
          dout_d  = shifted[FIRST];
          cnt_d   = cnt_q + 1'b1;
          // ready_q is low whenever pending_q is set, so accept here
          // always lands in an empty holding register.
          if (accept) begin
            hold_d    = din;
            pending_d = 1'b1;
            ready_d   = 1'b0;
          end
        end else begin
          done_d = 1'b1;
          cnt_d  = '0;
          if (pending_q) begin
            shreg_d   = hold_q;
            dout_d    = hold_q[FIRST];
            pending_d = 1'b0;
            ready_d   = 1'b1;
          end else if (accept) begin
            // Load on the last-bit edge streams straight through.
            shreg_d = din;
            dout_d  = din[FIRST];
          end else begin
            state_d  = IDLE;
            dvalid_d = 1'b0;
            dout_d   = 1'b0;
          end
        end
      end

      default: begin
        state_d  = IDLE;
        dvalid_d = 1'b0;
        dout_d   = 1'b0;
      end
    endcase
  end

  assign ready  = ready_q;
  assign dout   = dout_q;
  assign dvalid = dvalid_q;
  assign done   = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer (WIDTH=8, MSB_FIRST=1).
module tb_piso_serializer;

  localparam int W    = 8;
  localparam int MSB  = 1;
  localparam int MAXC = 300;

  logic         clk;
  logic         reset;
  logic         load;
  logic [W-1:0] din;
  logic         ready, dout, dvalid, done;

  int total = 0;
  int bad   = 0;

  // stimulus per edge (index = edge number after the last reset release)
  logic         st_l [0:MAXC];
  logic [W-1:0] st_d [0:MAXC];
  // observed / expected values during the cycle following each edge
  logic o_dv [0:MAXC], o_do [0:MAXC], o_dn [0:MAXC], o_rd [0:MAXC];
  logic e_dv [0:MAXC], e_do [0:MAXC], e_dn [0:MAXC], e_rd [0:MAXC];

  piso_serializer #(.WIDTH(W), .MSB_FIRST(MSB)) dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .din    (din),
    .ready  (ready),
    .dout   (dout),
    .dvalid (dvalid),
    .done   (done)
  );

  initial clk = 1'b0;
  always #15 clk = ~clk;

  task automatic clear_stim();
    for (int c = 0; c <= MAXC; c++) begin
      st_l[c] = 1'b0;
      st_d[c] = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load  = 1'b0;
    din   = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Drive the stimulus table for n edges and record what comes out.
  task automatic run_seq(input int n);
    for (int c = 1; c <= n; c++) begin
      load = st_l[c];
      din  = st_d[c];
      @(posedge clk);
      #1;
      o_dv[c] = dvalid;
      o_do[c] = dout;
      o_dn[c] = done;
      o_rd[c] = ready;
    end
    load = 1'b0;
  endtask

  // Reference: a word occupies the line for W cycles; one more word may
  // wait in a buffer; the buffer is offered (ready) whenever it is empty.
  // rem = bits of the current word still to appear, counting the one on
  // the line now.
  task automatic predict(input int n);
    int           rem, b;
    bit           pend, acc, dn;
    logic [W-1:0] cur, hold;
    rem = 0; b = 0; pend = 0; cur = '0; hold = '0;
    for (int c = 1; c <= n; c++) begin
      acc = st_l[c] && !pend;
      dn  = 0;
      if (rem == 0) begin
        if (acc) begin cur = st_d[c]; b = 0; rem = W; end
      end else if (rem > 1) begin
        b++; rem--;
        if (acc) begin hold = st_d[c]; pend = 1; end
      end else begin
        dn = 1;
        if (pend)     begin cur = hold;    b = 0; rem = W; pend = 0; end
        else if (acc) begin cur = st_d[c]; b = 0; rem = W; end
        else rem = 0;
      end
      e_dv[c] = (rem > 0);
      e_do[c] = (rem > 0) ? cur[(MSB != 0) ? (W - 1 - b) : b] : 1'b0;
      e_dn[c] = dn;
      e_rd[c] = !pend;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    load  = 1'b1;
    din   = 8'hFF;
    #1;
    total++;
    if ({ready, dvalid, dout, done} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_early rd/dv/do/dn got=%b want=1000", {ready, dvalid, dout, done});
    end
    @(posedge clk);
    #1;
    total++;
    if ({ready, dvalid, dout, done} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_edge rd/dv/do/dn got=%b want=1000", {ready, dvalid, dout, done});
    end
    @(posedge clk);
    #1;
    total++;
    if ({ready, dvalid, dout, done} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_hold rd/dv/do/dn got=%b want=1000", {ready, dvalid, dout, done});
    end
    load  = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({ready, dvalid, dout, done} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_release rd/dv/do/dn got=%b want=1000", {ready, dvalid, dout, done});
    end
  endtask

  task automatic test_single();
    logic [W-1:0] a;
    int n = 12;
    do_reset();
    clear_stim();
    st_l[1] = 1'b1;
    st_d[1] = 8'hA5;
    run_seq(n);
    predict(n);
    for (int c = 1; c <= n; c++) begin
      total++;
      if ({o_dv[c], o_do[c], o_dn[c], o_rd[c]} !== {e_dv[c], e_do[c], e_dn[c], e_rd[c]}) begin
        bad++;
        $display("FAIL single c=%0d dv/do/dn/rd got=%b want=%b", c,
                 {o_dv[c], o_do[c], o_dn[c], o_rd[c]}, {e_dv[c], e_do[c], e_dn[c], e_rd[c]});
      end
    end
    // downstream shift register picks up each valid bit
    a = '0;
    for (int c = 1; c <= n; c++) if (o_dv[c] === 1'b1) a = {a[W-2:0], o_do[c]};
    total++;
    if (a !== 8'hA5) begin
      bad++;
      $display("FAIL single_shift_reg got=%h want=a5", a);
    end
    total++;
    if ({o_dn[9], o_dv[9], o_dv[8]} !== 3'b101) begin
      bad++;
      $display("FAIL single_done9 dn9/dv9/dv8 got=%b want=101", {o_dn[9], o_dv[9], o_dv[8]});
    end
  endtask

  task automatic test_back_to_back();
    int n = 22;
    int nvalid;
    do_reset();
    clear_stim();
    st_l[1] = 1'b1; st_d[1] = 8'hFF;
    st_l[3] = 1'b1; st_d[3] = 8'h00;
    run_seq(n);
    predict(n);
    for (int c = 1; c <= n; c++) begin
      total++;
      if ({o_dv[c], o_do[c], o_dn[c], o_rd[c]} !== {e_dv[c], e_do[c], e_dn[c], e_rd[c]}) begin
        bad++;
        $display("FAIL b2b c=%0d dv/do/dn/rd got=%b want=%b", c,
                 {o_dv[c], o_do[c], o_dn[c], o_rd[c]}, {e_dv[c], e_do[c], e_dn[c], e_rd[c]});
      end
    end
    total++;
    if ({o_rd[2], o_rd[3], o_rd[8], o_rd[9]} !== 4'b1001) begin
      bad++;
      $display("FAIL b2b_ready rd2/3/8/9 got=%b want=1001", {o_rd[2], o_rd[3], o_rd[8], o_rd[9]});
    end
    total++;
    if ({o_dn[8], o_dn[9], o_dn[16], o_dn[17], o_dn[18]} !== 5'b01010) begin
      bad++;
      $display("FAIL b2b_done dn8/9/16/17/18 got=%b want=01010",
               {o_dn[8], o_dn[9], o_dn[16], o_dn[17], o_dn[18]});
    end
    nvalid = 0;
    for (int c = 1; c <= 16; c++) if (o_dv[c] === 1'b1 && o_do[c] === (c <= 8)) nvalid++;
    total++;
    if (nvalid != 16 || o_dv[17] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_stream good_bits got=%0d want=16 dv17 got=%b want=0", nvalid, o_dv[17]);
    end
  endtask

  task automatic test_overflow();
    int n = 24;
    int nvalid;
    do_reset();
    clear_stim();
    st_l[1] = 1'b1; st_d[1] = 8'($urandom);
    st_l[2] = 1'b1; st_d[2] = 8'($urandom);
    for (int c = 3; c <= 8; c++) begin st_l[c] = 1'b1; st_d[c] = 8'h3C; end
    run_seq(n);
    predict(n);
    for (int c = 1; c <= n; c++) begin
      total++;
      if ({o_dv[c], o_do[c], o_dn[c], o_rd[c]} !== {e_dv[c], e_do[c], e_dn[c], e_rd[c]}) begin
        bad++;
        $display("FAIL overflow c=%0d dv/do/dn/rd got=%b want=%b", c,
                 {o_dv[c], o_do[c], o_dn[c], o_rd[c]}, {e_dv[c], e_do[c], e_dn[c], e_rd[c]});
      end
    end
    nvalid = 0;
    for (int c = 1; c <= n; c++) if (o_dv[c] === 1'b1) nvalid++;
    total++;
    if (nvalid != 16) begin
      bad++;
      $display("FAIL overflow_len valid_cycles got=%0d want=16", nvalid);
    end
  endtask

  task automatic test_last_edge();
    int n = 20;
    logic [W-1:0] a;
    do_reset();
    clear_stim();
    st_l[1] = 1'b1; st_d[1] = 8'($urandom);
    st_l[9] = 1'b1; st_d[9] = 8'h81;
    run_seq(n);
    predict(n);
    for (int c = 1; c <= n; c++) begin
      total++;
      if ({o_dv[c], o_do[c], o_dn[c], o_rd[c]} !== {e_dv[c], e_do[c], e_dn[c], e_rd[c]}) begin
        bad++;
        $display("FAIL last_edge c=%0d dv/do/dn/rd got=%b want=%b", c,
                 {o_dv[c], o_do[c], o_dn[c], o_rd[c]}, {e_dv[c], e_do[c], e_dn[c], e_rd[c]});
      end
    end
    a = '0;
    for (int c = 9; c <= 16; c++) a = {a[W-2:0], o_do[c] & o_dv[c]};
    total++;
    if (a !== 8'h81 || o_dv[17] !== 1'b0) begin
      bad++;
      $display("FAIL last_edge_word got=%h dv17=%b want=81 dv17=0", a, o_dv[17]);
    end
  endtask

  task automatic test_reset_mid();
    int n = 16;
    int seen_dv, seen_dn;
    do_reset();
    clear_stim();
    st_l[1] = 1'b1; st_d[1] = 8'hF0;
    st_l[2] = 1'b1; st_d[2] = 8'($urandom);
    run_seq(4);
    // bit 3 of F0 is on the line; abort in mid-cycle
    #5;
    reset = 1'b1;
    #1;
    total++;
    if ({ready, dvalid, dout, done} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_mid_async rd/dv/do/dn got=%b want=1000", {ready, dvalid, dout, done});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    seen_dv = 0;
    seen_dn = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk);
      #1;
      if (dvalid !== 1'b0) seen_dv++;
      if (done !== 1'b0) seen_dn++;
    end
    total++;
    if (seen_dv != 0 || seen_dn != 0) begin
      bad++;
      $display("FAIL reset_mid_quiet dvalid_cycles=%0d done_cycles=%0d want 0 and 0", seen_dv, seen_dn);
    end
    clear_stim();
    st_l[1] = 1'b1; st_d[1] = 8'($urandom);
    run_seq(n);
    predict(n);
    for (int c = 1; c <= n; c++) begin
      total++;
      if ({o_dv[c], o_do[c], o_dn[c], o_rd[c]} !== {e_dv[c], e_do[c], e_dn[c], e_rd[c]}) begin
        bad++;
        $display("FAIL reset_mid_fresh c=%0d dv/do/dn/rd got=%b want=%b", c,
                 {o_dv[c], o_do[c], o_dn[c], o_rd[c]}, {e_dv[c], e_do[c], e_dn[c], e_rd[c]});
      end
    end
  endtask

  task automatic test_random();
    int n = 250;
    do_reset();
    clear_stim();
    for (int c = 1; c <= n - 20; c++) begin
      st_l[c] = ($urandom_range(0, 99) < 35);
      st_d[c] = 8'($urandom);
    end
    run_seq(n);
    predict(n);
    for (int c = 1; c <= n; c++) begin
      total++;
      if ({o_dv[c], o_do[c], o_dn[c], o_rd[c]} !== {e_dv[c], e_do[c], e_dn[c], e_rd[c]}) begin
        bad++;
        $display("FAIL random c=%0d dv/do/dn/rd got=%b want=%b", c,
                 {o_dv[c], o_do[c], o_dn[c], o_rd[c]}, {e_dv[c], e_do[c], e_dn[c], e_rd[c]});
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    load  = 1'b0;
    din   = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_last_edge();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out serializer: the transmit-side counterpart of the team's 8-bit serial-in/parallel-out shift register. It accepts a WIDTH-bit word on a load handshake and emits it one bit per clock on `dout`, qualified by `dvalid`. A one-word holding buffer allows back-to-back words with no idle bit between them. `dout` drives the `din` of a downstream shift_reg.

## Interface
- `WIDTH`, default 8: word width in bits; legal range 2..32.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

Ports:
- `clk`  input  1: single clock, rising-edge active.
- `reset`  input  1: asynchronous, active-high; clears all state immediately.
- `load`  input  1: word-offer strobe; accepted on a rising edge where `load && ready`.
- `din`  input  WIDTH: parallel word; sampled only on an accepted load.
- `ready`  output  1: registered; 1 means the block can accept a word this cycle.
- `dout`  output  1: registered serial data.
- `dvalid`  output  1: registered; 1 while `dout` carries a valid bit.
- `done`  output  1: registered one-cycle pulse marking the end of each word.

## Operation
- State machine has two states, IDLE and SHIFT.
- Internal storage:
  - shift register `shreg` (WIDTH bits);
  - bit counter `cnt` (ceil(log2(WIDTH)) bits, counts 0..WIDTH-1);
  - holding register `hold` (WIDTH bits) and `pending` flag.
- Reset values: state IDLE, `shreg`=0, `hold`=0, `cnt`=0, `pending`=0, `ready`=1, `dout`=0, `dvalid`=0, `done`=0.
- In IDLE:
  - On an accepted load, `shreg` takes `din`, `dout` takes the first bit of `din`, `dvalid` goes to 1, `cnt` goes to 0, and the state moves to SHIFT.
  - Otherwise `dout` and `dvalid` stay 0.
- In SHIFT, at each edge where `cnt` < WIDTH-1: `shreg` shifts toward the output end, `dout` takes the next bit, and `cnt` increments.
- Load in SHIFT, away from the last-bit edge: an accepted load writes `din` into `hold`, sets `pending`=1, and drives `ready`=0 on the next cycle.
- At the last-bit edge (`cnt`=WIDTH-1) in SHIFT, `done` goes to 1 for one cycle. The next action depends on `pending` and `load`:
  - `pending`=1: `hold` moves to `shreg`, the first bit of that word goes to `dout`, `dvalid` stays 1, `cnt`=0, `pending`=0, and `ready`=1 from the next cycle.
  - `pending`=0 and `load`=1 (accepted, since `ready`=1): `din` loads directly and streams with no gap.
  - `pending`=0 and `load`=0: state goes to IDLE, `dvalid`=0, `dout`=0.
- `load` while `ready`=0 is ignored: `hold`, `pending` and the outputs are unchanged.
- A reset asserted mid-word aborts immediately:
  - all outputs and registers take their reset values asynchronously;
  - any pending word is discarded;
  - there is no `done` pulse for the aborted word.
- Bit order depends on `MSB_FIRST`:
  - `MSB_FIRST`=1 sends `din[WIDTH-1]`, then `din[WIDTH-2]`, …, then `din[0]`.
  - `MSB_FIRST`=0 sends the reverse order.

## Timing
- Latency: a load accepted at edge k puts the first bit on `dout` after edge k, for the cycle k to k+1.
- Bit j (0-based, in transmit order) is valid between edges k+j and k+j+1.
- Word duration is exactly WIDTH cycles with `dvalid`=1.
- `done` is high between edges k+WIDTH and k+WIDTH+1, which coincides with the first bit of the next word when streaming.
- Throughput: one bit per clock sustained. Back-to-back words have zero idle cycles, provided each next word is accepted before its predecessor's last-bit edge.
- `ready` is registered, so it deasserts one cycle after the accepting edge.
- All outputs are glitch-free flop outputs. Downstream samples `dout` on the rising edge following the one that launched it.

## Test plan
Use a 30 ns clock period.
- **Reset:** hold `reset`=1 for 1 period with `load`=1, `din`=8'hFF -> `ready`=1, `dvalid`=0, `dout`=0, `done`=0 throughout. There is no transfer until after reset.
- **Single word:** MSB_FIRST=1, load 8'hA5 -> `dout`=1,0,1,0,0,1,0,1 over 8 cycles with `dvalid`=1; `done` pulses in cycle 9; then IDLE with `dvalid`=0. A downstream shift_reg `a` reads 8'hA5.
- **Back-to-back:**
  - Stimulus: load 8'hFF, then load 8'h00 two cycles later.
  - Response: `ready`=0 from cycle 3 to cycle 8; 16 contiguous `dvalid` cycles carrying 8 ones then 8 zeros.
  - `done` pulses at cycles 9 and 17.
- **Overflow ignore:**
  - Stimulus: while `pending`=1, offer 8'h3C.
  - Response: it is not transmitted; only the first two words appear on `dout`.
- **Last-edge load:** `load`=1 with 8'h81 exactly at the last-bit edge with `pending`=0 -> no gap, and 8'h81 follows immediately.
- **Reset mid-word:** assert `reset` after bit 3 of 8'hF0, with a pending word -> outputs go to 0 at once, with no `done` and no pending-word transmission. A fresh load after reset transmits correctly.
